// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int MAX_N_IN = 4;

    function automatic int rows(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control, result and table-drive signals of one truth-table sweeper.
interface truth_table_sweeper_if #(
    parameter int N_IN = 4
);
    localparam int ROWS = tt_pkg::rows(N_IN);

    logic              start;
    logic [ROWS-1:0]   expected;
    logic [N_IN-1:0]   abcd;
    logic              y_in;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ROWS-1:0]   captured;
    logic              mismatch_valid;
    logic [N_IN-1:0]   mismatch_idx;

    // The controller / table side drives start, expected and y_in.
    modport master (
        output start, expected, y_in,
        input  abcd, busy, done, pass, captured, mismatch_valid, mismatch_idx
    );

    modport slave (
        input  start, expected, y_in,
        output abcd, busy, done, pass, captured, mismatch_valid, mismatch_idx
    );

endinterface

// File: rtl/lowest_set_index.sv
// Combinational priority encoder: index of the lowest set bit, 0 when none set.
module lowest_set_index #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] index,
    output logic             any_set
);

    // Scanning downward lets the lowest set bit win the final assignment.
    always_comb begin
        index   = '0;
        any_set = |vec;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks every input row of a combinational table, captures Y after a settle
// time and compares the captured table against a latched expected table.
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_sweeper_if.slave  bus
);

    localparam int              ROWS     = rows(N_IN);
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(ROWS - 1);
    localparam logic [3:0]      CNT_LAST = 4'(SETTLE - 1);

    state_e            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ROWS-1:0]   exp_q, exp_d;
    logic [ROWS-1:0]   captured_q, captured_d;
    logic              pass_q, pass_d;
    logic              mismatch_valid_q, mismatch_valid_d;
    logic [N_IN-1:0]   mismatch_idx_q, mismatch_idx_d;

    logic [ROWS-1:0]   diff;
    logic [N_IN-1:0]   diff_idx;
    logic              diff_any;

    assign diff = captured_q ^ exp_q;

    lowest_set_index #(
        .WIDTH (ROWS),
        .IDX_W (N_IN)
    ) u_first_diff (
        .vec     (diff),
        .index   (diff_idx),
        .any_set (diff_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            idx_q            <= '0;
            cnt_q            <= '0;
            exp_q            <= '0;
            captured_q       <= '0;
            pass_q           <= 1'b0;
            mismatch_valid_q <= 1'b0;
            mismatch_idx_q   <= '0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            cnt_q            <= cnt_d;
            exp_q            <= exp_d;
            captured_q       <= captured_d;
            pass_q           <= pass_d;
            mismatch_valid_q <= mismatch_valid_d;
            mismatch_idx_q   <= mismatch_idx_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        cnt_d            = cnt_q;
        exp_d            = exp_q;
        captured_d       = captured_q;
        pass_d           = pass_q;
        mismatch_valid_d = mismatch_valid_q;
        mismatch_idx_d   = mismatch_idx_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    exp_d            = bus.expected;
                    captured_d       = '0;
                    idx_d            = '0;
                    cnt_d            = '0;
                    pass_d           = 1'b0;
                    mismatch_valid_d = 1'b0;
                    state_d          = DRIVE;
                end
            end
            DRIVE: begin
                // Sample on the last edge of the row so Y has settled.
                if (cnt_q == CNT_LAST) begin
                    captured_d[idx_q] = bus.y_in;
                    cnt_d             = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = CHECK;
                    end else begin
                        idx_d = idx_q + N_IN'(1);
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CHECK: begin
                pass_d           = !diff_any;
                mismatch_valid_d = diff_any;
                mismatch_idx_d   = diff_idx;
                state_d          = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.abcd           = (state_q == DRIVE) ? idx_q : '0;
    assign bus.busy           = (state_q != IDLE);
    assign bus.done           = (state_q == DONE);
    assign bus.pass           = pass_q;
    assign bus.captured       = captured_q;
    assign bus.mismatch_valid = mismatch_valid_q;
    assign bus.mismatch_idx   = mismatch_idx_q;

endmodule
